// File: rtl/health_bar_render.sv
`default_nettype none
// ============================================================================
//  Module      : health_bar_render
//  Description : Per-player health bars. The CPU writes SET/DAMAGE/HEAL
//                commands into shadow registers; the frame tick commits
//                them to display registers. Each channel's hearts are
//                rendered as a row of notched glyphs at the current pixel,
//                and the bar blinks for a few frames after losing health.
//  Revision    : 1.0 - initial release
// ============================================================================
module health_bar_render #(
    parameter int NUM_CH       = 2,
    parameter int HP_W         = 4,
    parameter int MAX_HP       = 10,
    parameter int INIT_HP      = 5,
    parameter int HEART_W      = 16,
    parameter int HEART_H      = 16,
    parameter int GAP          = 4,
    parameter int BAR_Y0       = 8,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 write_en0,
    input  logic                 right_addr,
    input  logic [31:0]          pwdata,
    input  logic                 animate,
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    input  logic [NUM_CH*10-1:0] x_base,
    output logic                 h,
    output logic [NUM_CH-1:0]    h_ch,
    output logic [NUM_CH-1:0]    blinking,
    output logic [NUM_CH-1:0]    dead
);

    // Blink counter needs at least two bits because bit 1 sets the cadence
    localparam int c_CNT_W = ($clog2(BLINK_FRAMES + 1) < 2) ? 2 : $clog2(BLINK_FRAMES + 1);

    localparam logic [HP_W-1:0]    c_MAX_HP   = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0]    c_INIT_HP  = HP_W'(INIT_HP);
    localparam logic [HP_W:0]      c_MAX_HP_X = (HP_W + 1)'(MAX_HP);
    localparam logic [c_CNT_W-1:0] c_BLINK    = c_CNT_W'(BLINK_FRAMES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_OP_SET    = 2'b00;
    localparam logic [1:0] c_OP_DAMAGE = 2'b01;
    localparam logic [1:0] c_OP_HEAL   = 2'b10;

    localparam int c_STRIDE     = HEART_W + GAP;
    localparam int c_ROW_PITCH  = HEART_H + GAP;
    localparam int c_NOTCH_ROWS = HEART_H / 4;
    localparam int c_NOTCH_L    = HEART_W / 2 - 1;
    localparam int c_NOTCH_R    = HEART_W / 2;

    logic              w_wr;
    logic [1:0]        w_op;
    logic [7:0]        w_wr_ch;
    logic [HP_W-1:0]   w_val;
    logic [NUM_CH-1:0] w_hit;
    logic              w_unused;

    assign w_wr     = write_en0 && right_addr;
    assign w_op     = pwdata[31:30];
    assign w_wr_ch  = pwdata[23:16];
    assign w_val    = pwdata[HP_W-1:0];
    assign w_unused = &{1'b0, pwdata[29:24], pwdata[15:HP_W]};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam int c_ROW_Y = BAR_Y0 + c * c_ROW_PITCH;

            logic [HP_W-1:0]    r_shadow;
            logic [HP_W-1:0]    r_disp;
            logic [c_CNT_W-1:0] r_blink_cnt;
            logic [HP_W:0]      w_cur_x;
            logic [HP_W:0]      w_val_x;
            logic [HP_W:0]      w_sum;
            logic [HP_W-1:0]    w_next;
            logic               w_sel;
            logic               w_visible;
            logic               w_hit_c;

            assign w_cur_x = {1'b0, r_shadow};
            assign w_val_x = {1'b0, w_val};
            assign w_sum   = w_cur_x + w_val_x;
            assign w_sel   = w_wr && (w_wr_ch == 8'(c));

            // Saturating command arithmetic in HP_W+1 bits; reserved op holds
            always_comb begin
                w_next = r_shadow;
                case (w_op)
                    c_OP_SET:    w_next = (w_val_x > c_MAX_HP_X) ? c_MAX_HP : w_val;
                    c_OP_DAMAGE: w_next = (w_val_x > w_cur_x) ? '0 : (r_shadow - w_val);
                    c_OP_HEAL:   w_next = (w_sum > c_MAX_HP_X) ? c_MAX_HP : w_sum[HP_W-1:0];
                    default:     w_next = r_shadow;
                endcase
            end

            // Shadow takes writes; frame tick commits shadow and runs the blink timer
            always_ff @(posedge clk or negedge res) begin
                if (!res) begin
                    r_shadow    <= c_INIT_HP;
                    r_disp      <= c_INIT_HP;
                    r_blink_cnt <= '0;
                end else begin
                    if (w_sel) begin
                        r_shadow <= w_next;
                    end
                    if (animate) begin
                        r_disp <= r_shadow;
                        if (r_shadow < r_disp) begin
                            r_blink_cnt <= c_BLINK;
                        end else if (r_blink_cnt != '0) begin
                            r_blink_cnt <= r_blink_cnt - c_CNT_ONE;
                        end
                    end
                end
            end

            assign blinking[c] = (r_blink_cnt != '0);
            assign dead[c]     = (r_disp == '0);
            assign w_visible   = !((r_blink_cnt != '0) && r_blink_cnt[1]);

            // Hit test against every possible glyph slot; signed ints avoid wrap left of x_base
            always_comb begin
                int px;
                int xb;
                int ly;
                int lx;
                w_hit_c = 1'b0;
                px      = int'(x);
                xb      = int'(x_base[c*10 +: 10]);
                ly      = int'(y) - c_ROW_Y;
                lx      = 0;
                if (w_visible && (ly >= 0) && (ly < HEART_H)) begin
                    for (int k = 0; k < MAX_HP; k++) begin
                        lx = px - (xb + k * c_STRIDE);
                        if ((k < int'(r_disp)) && (lx >= 0) && (lx < HEART_W)) begin
                            if (!((ly < c_NOTCH_ROWS) && ((lx == c_NOTCH_L) || (lx == c_NOTCH_R)))) begin
                                w_hit_c = 1'b1;
                            end
                        end
                    end
                end
            end

            assign w_hit[c] = w_hit_c;
        end
    endgenerate

    // Register the pixel flags so the colour mux sees a clean one-cycle latency
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            h_ch <= '0;
            h    <= 1'b0;
        end else begin
            h_ch <= w_hit;
            h    <= |w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_health_bar_render.sv
`default_nettype none
// ============================================================================
//  Module      : tb_health_bar_render
//  Description : Self-checking bench for health_bar_render. Pixel vectors
//                are tabulated; expected outputs ride a queue and are popped
//                when the registered pixel flags appear one clock later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_health_bar_render;

    logic        clk        = 1'b0;
    logic        res        = 1'b0;
    logic        write_en0  = 1'b0;
    logic        right_addr = 1'b0;
    logic [31:0] pwdata     = '0;
    logic        animate    = 1'b0;
    logic [9:0]  x          = '0;
    logic [8:0]  y          = '0;
    logic [19:0] x_base     = {10'd300, 10'd100};
    logic        h;
    logic [1:0]  h_ch;
    logic [1:0]  blinking;
    logic [1:0]  dead;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] px;
        logic [8:0] py;
        logic [1:0] hch;
    } vec_t;

    vec_t       vq[$];
    logic [1:0] exp_q[$];

    // Visibility of channel 0 for blink counts 7 down to 0
    int vis[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    always #5 clk = ~clk;

    health_bar_render dut (
        .clk        (clk),
        .res        (res),
        .write_en0  (write_en0),
        .right_addr (right_addr),
        .pwdata     (pwdata),
        .animate    (animate),
        .x          (x),
        .y          (y),
        .x_base     (x_base),
        .h          (h),
        .h_ch       (h_ch),
        .blinking   (blinking),
        .dead       (dead)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic [1:0] hch);
        vec_t v;
        v.px  = px;
        v.py  = py;
        v.hch = hch;
        vq.push_back(v);
    endtask

    // Stream the vector table; each expectation is popped when its output is due
    task automatic run_pixels(input string name);
        logic [1:0] e;
        for (int i = 0; i < vq.size(); i++) begin
            x = vq[i].px;
            y = vq[i].py;
            exp_q.push_back(vq[i].hch);
            tick();
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", name, i), {29'b0, h, h_ch}, {29'b0, |e, e});
        end
        vq.delete();
    endtask

    task automatic apb(input logic [1:0] op, input logic [7:0] ch, input logic [3:0] v);
        write_en0  = 1'b1;
        right_addr = 1'b1;
        pwdata     = {op, 6'b0, ch, 12'b0, v};
        tick();
        write_en0  = 1'b0;
        right_addr = 1'b0;
        pwdata     = '0;
    endtask

    task automatic frame();
        animate = 1'b1;
        tick();
        animate = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("reset_pix", {29'b0, h, h_ch}, 32'h0);
        check("reset_blink", {30'b0, blinking}, 32'h0);
        check("reset_dead", {30'b0, dead}, 32'h0);
        @(posedge clk);
        #1;
        res = 1'b1;

        // Geometry with five hearts on both channels
        pix(10'd99,  9'd8,  2'b00);
        pix(10'd100, 9'd8,  2'b01);
        pix(10'd115, 9'd8,  2'b01);
        pix(10'd116, 9'd8,  2'b00);
        pix(10'd119, 9'd8,  2'b00);
        pix(10'd120, 9'd8,  2'b01);
        pix(10'd135, 9'd8,  2'b01);
        pix(10'd195, 9'd8,  2'b01);
        pix(10'd196, 9'd8,  2'b00);
        pix(10'd107, 9'd8,  2'b00);
        pix(10'd108, 9'd8,  2'b00);
        pix(10'd106, 9'd8,  2'b01);
        pix(10'd109, 9'd8,  2'b01);
        pix(10'd107, 9'd11, 2'b00);
        pix(10'd107, 9'd12, 2'b01);
        pix(10'd100, 9'd23, 2'b01);
        pix(10'd100, 9'd24, 2'b00);
        pix(10'd100, 9'd7,  2'b00);
        pix(10'd0,   9'd8,  2'b00);
        pix(10'd300, 9'd28, 2'b10);
        pix(10'd307, 9'd28, 2'b00);
        pix(10'd395, 9'd43, 2'b10);
        pix(10'd396, 9'd43, 2'b00);
        run_pixels("geom");

        // Bar origin near the right edge must not wrap to small x
        x_base[9:0] = 10'd1000;
        pix(10'd1000, 9'd8, 2'b01);
        pix(10'd1023, 9'd8, 2'b01);
        pix(10'd5,    9'd8, 2'b00);
        pix(10'd29,   9'd8, 2'b00);
        run_pixels("nowrap");
        x_base[9:0] = 10'd100;

        // Damage is held in shadow until the frame tick
        apb(2'b01, 8'd0, 4'd2);
        pix(10'd180, 9'd12, 2'b01);
        run_pixels("dmg_pre");
        frame();
        check("dmg_blink", {30'b0, blinking}, 32'h1);
        check("dmg_dead", {30'b0, dead}, 32'h0);
        pix(10'd140, 9'd12, 2'b01);
        pix(10'd160, 9'd12, 2'b00);
        run_pixels("dmg_post");

        // Blink cadence through the remaining eight ticks
        for (int i = 0; i < 8; i++) begin
            frame();
            check($sformatf("blink_flag[%0d]", i), {31'b0, blinking[0]}, (i < 7) ? 32'h1 : 32'h0);
            pix(10'd100, 9'd12, (vis[i] != 0) ? 2'b01 : 2'b00);
            run_pixels($sformatf("blink_vis%0d", i));
        end

        // Overkill damage then overheal on channel 1
        apb(2'b01, 8'd1, 4'd15);
        frame();
        check("kill_dead", {30'b0, dead}, 32'h2);
        check("kill_blink", {30'b0, blinking}, 32'h2);
        pix(10'd300, 9'd28, 2'b00);
        pix(10'd100, 9'd12, 2'b01);
        run_pixels("kill_pix");
        apb(2'b10, 8'd1, 4'd15);
        frame();
        check("heal_dead", {30'b0, dead}, 32'h0);
        check("heal_blink", {30'b0, blinking}, 32'h2);
        pix(10'd300, 9'd32, 2'b00);
        run_pixels("heal_hidden");
        for (int i = 0; i < 7; i++) frame();
        check("heal_blink_end", {30'b0, blinking}, 32'h0);
        pix(10'd480, 9'd32, 2'b10);
        pix(10'd495, 9'd32, 2'b10);
        pix(10'd496, 9'd32, 2'b00);
        pix(10'd500, 9'd32, 2'b00);
        pix(10'd300, 9'd43, 2'b10);
        run_pixels("heal_max");

        // Write coinciding with the frame tick lands on the following tick
        write_en0  = 1'b1;
        right_addr = 1'b1;
        pwdata     = {2'b00, 6'b0, 8'd0, 12'b0, 4'd7};
        animate    = 1'b1;
        tick();
        write_en0  = 1'b0;
        right_addr = 1'b0;
        pwdata     = '0;
        animate    = 1'b0;
        pix(10'd140, 9'd12, 2'b01);
        pix(10'd160, 9'd12, 2'b00);
        run_pixels("same_cyc_old");
        frame();
        check("set7_blink", {30'b0, blinking}, 32'h0);
        pix(10'd220, 9'd12, 2'b01);
        pix(10'd240, 9'd12, 2'b00);
        run_pixels("same_cyc_new");

        // Out-of-range channel, reserved op and a missed address decode do nothing
        apb(2'b01, 8'd5, 4'd3);
        apb(2'b11, 8'd0, 4'd0);
        write_en0  = 1'b1;
        right_addr = 1'b0;
        pwdata     = {2'b01, 6'b0, 8'd0, 12'b0, 4'd3};
        tick();
        write_en0  = 1'b0;
        pwdata     = '0;
        frame();
        check("ign_dead", {30'b0, dead}, 32'h0);
        check("ign_blink", {30'b0, blinking}, 32'h0);
        pix(10'd220, 9'd12, 2'b01);
        pix(10'd240, 9'd12, 2'b00);
        pix(10'd480, 9'd32, 2'b10);
        run_pixels("ignored");

        // Back-to-back writes apply in order
        apb(2'b01, 8'd0, 4'd1);
        apb(2'b10, 8'd0, 4'd2);
        frame();
        check("b2b_blink", {30'b0, blinking}, 32'h0);
        pix(10'd240, 9'd12, 2'b01);
        pix(10'd260, 9'd12, 2'b00);
        run_pixels("b2b");

        // SET saturates at the ceiling
        apb(2'b00, 8'd0, 4'd14);
        frame();
        pix(10'd280, 9'd12, 2'b01);
        pix(10'd300, 9'd12, 2'b00);
        run_pixels("set_sat");

        // Heal saturates first, then damage: 10 -> 10 -> 6
        apb(2'b10, 8'd0, 4'd3);
        apb(2'b01, 8'd0, 4'd4);
        frame();
        check("order_blink", {30'b0, blinking}, 32'h1);
        pix(10'd200, 9'd12, 2'b01);
        pix(10'd220, 9'd12, 2'b00);
        run_pixels("order");

        // Asynchronous reset in the middle of a blink
        x = 10'd100;
        y = 9'd12;
        tick();
        check("pre_reset_h", {31'b0, h}, 32'h1);
        #2;
        res = 1'b0;
        #1;
        check("async_pix", {29'b0, h, h_ch}, 32'h0);
        check("async_blink", {30'b0, blinking}, 32'h0);
        check("async_dead", {30'b0, dead}, 32'h0);
        tick();
        res = 1'b1;
        pix(10'd195, 9'd12, 2'b01);
        pix(10'd200, 9'd12, 2'b00);
        pix(10'd395, 9'd32, 2'b10);
        pix(10'd400, 9'd32, 2'b00);
        run_pixels("post_reset");
        frame();
        check("post_reset_blink", {30'b0, blinking}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/health_bar_render.md
Name: health_bar_render

Overview:
- Per-frame health display for NUM_CH players. The CPU writes health commands over the APB slave strobe into per-channel shadow registers.
- Shadow values are committed to the display registers on the frame tick (animate), so a bar never tears mid-frame.
- The block renders each channel's hearts as a row of glyphs at the current VGA pixel (x,y) and outputs a registered pixel-on flag to the colour mux.
- It blinks a channel's bar for a few frames after that channel loses health.

Parameters:
NUM_CH, 2, number of health channels (players)
HP_W, 4, width of a health value
MAX_HP, 10, saturation ceiling for health (must be less than 2^HP_W)
INIT_HP, 5, health loaded at reset
HEART_W, 16, glyph width in pixels
HEART_H, 16, glyph height in pixels
GAP, 4, horizontal gap between glyphs and vertical gap between channel rows
BAR_Y0, 8, top y of channel 0's row
BLINK_FRAMES, 8, animate ticks a bar blinks after damage

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-low reset
write_en0  in  1  APB write strobe
right_addr  in  1  address decode hit for this block
pwdata  in  32  APB write data
animate  in  1  one-cycle frame tick
x  in  10  current pixel column
y  in  9  current pixel row
x_base  in  NUM_CH*10  per-channel bar origin column; channel c uses bits [c*10+9:c*10]
h  out  1  pixel belongs to a visible heart
h_ch  out  NUM_CH  one-hot: which channel's heart is at the pixel
blinking  out  NUM_CH  channel is in its blink window
dead  out  NUM_CH  committed health of the channel is 0

Behaviour:
- Reset (res low, asynchronous):
  - shadow[c] = INIT_HP and disp[c] = INIT_HP for every channel.
  - blink_cnt[c] = 0.
  - h = 0, h_ch = 0.
- Write accept: a write is accepted when write_en0 && right_addr is high on a clk edge. Fields of pwdata:
  - [31:30] op: 00 SET, 01 DAMAGE, 10 HEAL, 11 reserved (write ignored).
  - [23:16] channel index. An index >= NUM_CH is ignored.
  - [HP_W-1:0] value v.
- Op arithmetic on shadow[ch]:
  - SET: shadow = min(v, MAX_HP).
  - DAMAGE: shadow = shadow - v, saturating at 0.
  - HEAL: shadow = shadow + v, saturating at MAX_HP.
  - Arithmetic uses HP_W+1 bits so there is no wrap.
- Back-to-back writes each take effect in order, one per cycle.
- Commit, on the cycle animate is high, for every c:
  - disp[c] takes the shadow[c] value as it was before that edge.
  - A write in the same cycle updates shadow and lands on the next animate.
- Blink counter, evaluated on animate:
  - If the new disp is less than the old disp, blink_cnt is loaded with BLINK_FRAMES.
  - Otherwise, if blink_cnt is nonzero, it decrements by 1.
  - A fresh decrease while already blinking reloads the counter.
- Flags:
  - blinking[c] = (blink_cnt[c] != 0).
  - dead[c] = (disp[c] == 0), combinational from the registers.
- Geometry for channel c:
  - Row top yc = BAR_Y0 + c*(HEART_H+GAP).
  - Glyph k (0 <= k < disp[c]) spans columns x_base_c + k*(HEART_W+GAP) to x_base_c + k*(HEART_W+GAP) + HEART_W - 1.
  - It spans rows yc to yc+HEART_H-1.
- Glyph mask: solid box, except the top notch is off. The notch is local rows 0 to HEART_H/4-1 at local columns HEART_W/2-1 and HEART_W/2.
- Visibility: a channel's glyphs are suppressed when blinking[c] && blink_cnt[c][1]. This gives a 2-frames-on / 2-frames-off cadence.
- Pixel outputs:
  - h_ch[c] = 1 when (x,y) lies in a visible glyph pixel of channel c.
  - h = OR of h_ch.
  - Both are registered: latency is exactly 1 clk from x,y.
- Corner cases:
  - x < x_base_c yields no hit; no negative wrap is allowed.
  - Overlapping channel rows are legal, and h_ch may then be multi-hot.
  - Pixels in gap columns are off.
- Reset mid-frame or mid-blink: all state returns to the reset values immediately.

Test Plan:
- Reset → disp=5 on both channels. With x_base_0=100 and y=8, h=1 for x=100..115, 0 for x=116..119, 1 for x=120..135. Five glyphs end at x=195, and h=0 at x=196. Output appears one cycle after x.
- Notch check: y=8, x=107 or 108 on ch0 → h=0. y=12, x=107 → h=1.
- DAMAGE ch0 by 2 → disp stays 5 until animate, then becomes 3 and blinking[0]=1. Over the next ticks:
  - Glyphs are hidden while cnt=7 and 6, visible at 5 and 4, hidden at 3 and 2, visible at 1.
  - After 8 further animates blinking[0]=0.
- DAMAGE ch1 by 15 from 5 → after animate disp=0, dead[1]=1, and no ch1 pixels. HEAL ch1 by 15 → after animate disp=10 (MAX_HP), blinking unaffected.
- Write SET ch0=7 in the same cycle as animate → disp stays at the old value and becomes 7 on the next animate. Channel index 5 and op 11 writes → no state change.
- Assert res low in the middle of a blink → blink_cnt=0, disp=5, h=0 asynchronously, before the next clk edge.
